// File: rtl/ofd_arb_pkg.sv
// Shared types and the round-robin pick helper for the ofd_out_arb output arbiter.
package ofd_arb_pkg;

  localparam int MAX_N = 8;
  localparam int IDX_W = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // First requesting index at or above ptr, wrapping within n entries.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input logic [IDX_W-1:0] ptr,
                                               input int n);
    logic [IDX_W-1:0] pick;
    logic found;
    int idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ofd_out_arb_if.sv
// Requester/arbiter bundle for ofd_out_arb: requests and data in, grant and output register out.
interface ofd_out_arb_if #(
  parameter int N = 3,
  parameter int W = 3
);
  localparam int OWN_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     REQ;
  logic [N-1:0]     LAST;
  logic [N*W-1:0]   D;
  logic [N-1:0]     GNT;
  logic [N-1:0]     ACK;
  logic [OWN_W-1:0] OWNER;
  logic [W-1:0]     Q;
  logic             QV;
  logic             TOUT_ERR;

  modport master (
    output REQ, LAST, D,
    input  GNT, ACK, OWNER, Q, QV, TOUT_ERR
  );

  modport slave (
    input  REQ, LAST, D,
    output GNT, ACK, OWNER, Q, QV, TOUT_ERR
  );
endinterface

// File: rtl/ofd_out_reg.sv
// Shared OFD-style output flop bank: Q loads on a transfer, QV flags that edge.
module ofd_out_reg #(
  parameter int W = 3
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         qv
);

  logic [W-1:0] q_p1;
  logic         vld_p1;

  // Stage p1: single output register stage, cleared so no stale word survives reset.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      q_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= load;
      if (load) q_p1 <= d;
    end
  end

  assign q  = q_p1;
  assign qv = vld_p1;

endmodule

// File: rtl/ofd_out_arb.sv
// Round-robin burst arbiter sharing one output flop bank between N requesters.
// Optional burst timeout enabled by defining OFD_ARB_TOUT_EN.
module ofd_out_arb
  import ofd_arb_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = 3,
  parameter int GAP_CYC = 1,
  parameter int MAX_BST = 16
) (
  input logic           CK,
  input logic           RST,
  ofd_out_arb_if.slave  bus
);

  localparam int OWN_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(N - 1);

  arb_state_t       state, state_n;
  logic [N-1:0]     gnt, gnt_n;
  logic [OWN_W-1:0] owner, owner_n;
  logic [OWN_W-1:0] ptr, ptr_n;
  logic [OWN_W-1:0] pick;
  logic [3:0]       gap_cnt, gap_n;
  logic             tout_hit;
  logic             load;
  logic [W-1:0]     sel_d;

`ifdef OFD_ARB_TOUT_EN
  localparam logic [7:0] BST_LAST = 8'(MAX_BST - 1);
  logic [7:0] bst_cnt, bst_n;
  logic       tout_err, tout_n;
  assign tout_hit = (bst_cnt == BST_LAST);
`else
  logic [7:0] unused_bst;
  assign unused_bst = 8'(MAX_BST);
  assign tout_hit   = 1'b0;
`endif

  // The scan starts at ptr, which always sits one past the previous owner.
  assign pick = OWN_W'(rr_pick(MAX_N'(bus.REQ), IDX_W'(ptr), N));

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == OWN_W'(i)) sel_d = bus.D[i*W +: W];
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    gap_n   = gap_cnt;
    load    = 1'b0;
`ifdef OFD_ARB_TOUT_EN
    bst_n   = bst_cnt;
    tout_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|bus.REQ) begin
          gnt_n   = N'(1) << pick;
          owner_n = pick;
          ptr_n   = (pick == LAST_IDX) ? '0 : pick + 1'b1;
          state_n = GRANT;
`ifdef OFD_ARB_TOUT_EN
          bst_n   = '0;
`endif
        end
      end
      GRANT: begin
        load = bus.REQ[owner];
`ifdef OFD_ARB_TOUT_EN
        bst_n = bst_cnt + 8'd1;
`endif
        // LAST, a dropped request and a timeout all release at this same edge.
        if (!bus.REQ[owner] || bus.LAST[owner] || tout_hit) begin
          gnt_n   = '0;
          gap_n   = '0;
          state_n = (GAP_CYC == 0) ? IDLE : GAP;
`ifdef OFD_ARB_TOUT_EN
          tout_n  = tout_hit && bus.REQ[owner] && !bus.LAST[owner];
`endif
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else                     gap_n   = gap_cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      gap_cnt <= gap_n;
    end
  end

`ifdef OFD_ARB_TOUT_EN
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      bst_cnt  <= '0;
      tout_err <= 1'b0;
    end else begin
      bst_cnt  <= bst_n;
      tout_err <= tout_n;
    end
  end
  assign bus.TOUT_ERR = tout_err;
`else
  assign bus.TOUT_ERR = 1'b0;
`endif

  ofd_out_reg #(.W(W)) u_out (
    .CK   (CK),
    .RST  (RST),
    .load (load),
    .d    (sel_d),
    .q    (bus.Q),
    .qv   (bus.QV)
  );

  assign bus.GNT   = gnt;
  assign bus.ACK   = gnt & bus.REQ;
  assign bus.OWNER = owner;

endmodule

// File: tb/tb_ofd_out_arb.sv
// Directed bench for ofd_out_arb (N=3, W=3, GAP_CYC=1, MAX_BST=4); honours OFD_ARB_TOUT_EN.
module tb_ofd_out_arb;

  logic ck;
  logic rst;
  int   tests;
  int   fails;

  ofd_out_arb_if #(.N(3), .W(3)) bus ();

  ofd_out_arb #(.N(3), .W(3), .GAP_CYC(1), .MAX_BST(4)) dut (
    .CK  (ck),
    .RST (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         pre_rst;
    logic [2:0] req;
    logic [2:0] last;
    logic [8:0] d;
    logic [2:0] gnt;
    logic [2:0] ack;
    logic [1:0] owner;
    logic [2:0] q;
    logic       qv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit pr, input logic [2:0] rq, input logic [2:0] ls,
                              input logic [2:0] d2, input logic [2:0] d1, input logic [2:0] d0,
                              input logic [2:0] g, input logic [2:0] a, input logic [1:0] o,
                              input logic [2:0] q, input logic qv);
    vec_t v;
    v.pre_rst = pr; v.req = rq; v.last = ls; v.d = {d2, d1, d0};
    v.gnt = g; v.ack = a; v.owner = o; v.q = q; v.qv = qv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst = 1'b1;
    bus.REQ = '0; bus.LAST = '0; bus.D = '0;
    @(negedge ck);
    rst = 1'b0;
  endtask

  bit         e_gnt [11];
  bit         e_tout[11];
  int         tout_pulses;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.REQ = '0; bus.LAST = '0; bus.D = '0;

    // Power-on reset state
    #2;
    chk("rst gnt",   32'(bus.GNT), 0);
    chk("rst ack",   32'(bus.ACK), 0);
    chk("rst owner", 32'(bus.OWNER), 0);
    chk("rst q",     32'(bus.Q), 0);
    chk("rst qv",    32'(bus.QV), 0);
    chk("rst tout",  32'(bus.TOUT_ERR), 0);
    @(negedge ck);
    rst = 1'b0;

    // Reset asserted mid-burst with all requesters active
    do_reset();
    @(negedge ck);
    bus.REQ = 3'b111; bus.LAST = 3'b000; bus.D = {3'd4, 3'd2, 3'd1};
    #1 chk("mid idle gnt", 32'(bus.GNT), 0);
    @(negedge ck);
    #1 chk("mid gnt0", 32'(bus.GNT), 1);
    chk("mid ack0", 32'(bus.ACK), 1);
    @(negedge ck);
    #1 chk("mid q", 32'(bus.Q), 1);
    chk("mid qv", 32'(bus.QV), 1);
    #2 rst = 1'b1;
    #1 chk("async gnt",   32'(bus.GNT), 0);
    chk("async ack",   32'(bus.ACK), 0);
    chk("async q",     32'(bus.Q), 0);
    chk("async qv",    32'(bus.QV), 0);
    chk("async owner", 32'(bus.OWNER), 0);
    @(negedge ck);
    rst = 1'b0;
    #1 chk("post rst idle gnt", 32'(bus.GNT), 0);
    chk("post rst qv", 32'(bus.QV), 0);
    @(negedge ck);
    #1 chk("post rst first gnt", 32'(bus.GNT), 1);
    chk("post rst owner", 32'(bus.OWNER), 0);
    bus.REQ = '0;

    // Single requester 1 burst 3,5,6 then regrant; non-owner noise; owner 2 drop
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 3, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 0, 3, 0, 3'b010, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 0, 5, 0, 3'b010, 3'b010, 1, 3, 1));
    tbl.push_back(mk(0, 3'b010, 3'b010, 0, 6, 0, 3'b010, 3'b010, 1, 5, 1));
    tbl.push_back(mk(0, 3'b010, 3'b000, 0, 7, 0, 3'b000, 3'b000, 1, 6, 1));
    tbl.push_back(mk(0, 3'b010, 3'b000, 0, 7, 0, 3'b000, 3'b000, 1, 6, 0));
    tbl.push_back(mk(0, 3'b010, 3'b010, 0, 7, 0, 3'b010, 3'b010, 1, 6, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 1, 7, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 1, 7, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 2, 3'b000, 3'b000, 1, 7, 0));
    tbl.push_back(mk(0, 3'b111, 3'b110, 5, 4, 3, 3'b001, 3'b001, 0, 7, 0));
    tbl.push_back(mk(0, 3'b101, 3'b100, 6, 4, 1, 3'b001, 3'b001, 0, 3, 1));
    tbl.push_back(mk(0, 3'b011, 3'b011, 6, 5, 2, 3'b001, 3'b001, 0, 1, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 2, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 2, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 3, 0, 0, 3'b000, 3'b000, 0, 2, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 3, 0, 0, 3'b100, 3'b100, 2, 2, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 6, 0, 0, 3'b100, 3'b100, 2, 3, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 0, 0, 3'b100, 3'b000, 2, 6, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 2, 6, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 2, 6, 0));
    // All three requesting single-word bursts: order 0,1,2,0 with two idle cycles between
    tbl.push_back(mk(1, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b001, 3'b001, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 0, 4, 1));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 0, 4, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b010, 3'b010, 1, 4, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 1, 5, 1));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 1, 5, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b100, 3'b100, 2, 5, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 2, 6, 1));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b000, 3'b000, 2, 6, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 6, 5, 4, 3'b001, 3'b001, 0, 6, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0, 4, 1));

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      @(negedge ck);
      bus.REQ = tbl[i].req; bus.LAST = tbl[i].last; bus.D = tbl[i].d;
      #1;
      chk($sformatf("row%0d gnt", i),   32'(bus.GNT),      32'(tbl[i].gnt));
      chk($sformatf("row%0d ack", i),   32'(bus.ACK),      32'(tbl[i].ack));
      chk($sformatf("row%0d owner", i), 32'(bus.OWNER),    32'(tbl[i].owner));
      chk($sformatf("row%0d q", i),     32'(bus.Q),        32'(tbl[i].q));
      chk($sformatf("row%0d qv", i),    32'(bus.QV),       32'(tbl[i].qv));
      chk($sformatf("row%0d tout", i),  32'(bus.TOUT_ERR), 0);
    end

    // Requester 0 holds REQ for 10 cycles without LAST
`ifdef OFD_ARB_TOUT_EN
    e_gnt  = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    e_tout = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
`else
    e_gnt  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    e_tout = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    tout_pulses = 0;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge ck);
      bus.REQ  = (c < 10) ? 3'b001 : 3'b000;
      bus.LAST = 3'b000;
      bus.D    = {3'd0, 3'd0, 3'(c)};
      #1;
      chk($sformatf("tout c%0d gnt", c),  32'(bus.GNT),      32'(e_gnt[c]));
      chk($sformatf("tout c%0d flag", c), 32'(bus.TOUT_ERR), 32'(e_tout[c]));
      if (bus.TOUT_ERR === 1'b1) tout_pulses++;
      if (c == 5) begin
        chk("tout c5 q",  32'(bus.Q), 4);
        chk("tout c5 qv", 32'(bus.QV), 1);
      end
      if (c == 6) begin
`ifdef OFD_ARB_TOUT_EN
        chk("tout c6 q",  32'(bus.Q), 4);
        chk("tout c6 qv", 32'(bus.QV), 0);
`else
        chk("tout c6 q",  32'(bus.Q), 5);
        chk("tout c6 qv", 32'(bus.QV), 1);
`endif
      end
    end
`ifdef OFD_ARB_TOUT_EN
    chk("tout pulse count", 32'(tout_pulses), 1);
`else
    chk("tout pulse count", 32'(tout_pulses), 0);
`endif
    bus.REQ = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
